// File: rtl/dotprod_pkg.sv
// Shared definitions for the dot-product host/memory slice.
// FSM encodings, parameter defaults and the read range helper.
package dotprod_pkg;

    localparam int DW_DEF      = 32;
    localparam int AW_DEF      = 6;
    localparam int TIMEOUT_DEF = 4096;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD_A = 3'd1;
    localparam state_t ST_LOAD_B = 3'd2;
    localparam state_t ST_RUN    = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] n
    );
        return addr < n;
    endfunction

endpackage

// File: rtl/dotprod_bank.sv
// One vector bank: single write port, single read port.
// Reads beyond the loaded length return zero; READ_LAT selects comb/registered.
module dotprod_bank
    import dotprod_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int READ_LAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    input  logic [31:0]   raddr,
    input  logic [AW:0]   n,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic          hit;
    logic [DW-1:0] rd_comb;
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // addr < n <= DEPTH, so the low bits alone index a loaded word
    assign hit     = rd_en && in_range(raddr, 32'(n));
    assign rd_comb = hit ? mem[raddr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_comb;
        end
    end

    assign rdata = (READ_LAT == 0) ? rd_comb : rd_q;

endmodule

// File: rtl/dotprod_mem_host.sv
// Host/memory side of the dot-product kernel: loads banks, runs, captures.
// Optional DOTPROD_MEM_OOB_EN adds oob_sticky and folds it into res_err.
module dotprod_mem_host
    import dotprod_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int READ_LAT    = 0,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start,
    input  logic [AW:0]   cfg_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          kern_rst_n,
    output logic [AW:0]   kern_n,
    input  logic [31:0]   a_addr,
    input  logic          a_rd_en,
    output logic [DW-1:0] a_in,
    input  logic [31:0]   b_addr,
    input  logic          b_rd_en,
    output logic [DW-1:0] b_in,
    input  logic [DW-1:0] kern_result,
    input  logic          kern_done,
`ifdef DOTPROD_MEM_OOB_EN
    output logic          oob_sticky,
`endif
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          res_err,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    logic [AW:0]   len;
    logic [AW:0]   wptr;
    logic [CW-1:0] run_cnt;

    logic idle_or_done;
    logic start;
    logic beat;
    logic last_beat;
    logic len_bad;
    logic done_q;
    logic timeout;
    logic err_extra;

    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign start        = cfg_start && idle_or_done;
    assign ld_ready     = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    assign busy         = !idle_or_done;
    assign beat         = ld_valid && ld_ready;
    assign last_beat    = beat && (wptr == len - (AW + 1)'(1));
    assign len_bad      = cfg_len > (AW + 1)'(DEPTH);
    assign kern_n       = len;

    // a freshly released kernel may still show last job's done flag
    assign done_q  = (state == ST_RUN) && kern_done && (run_cnt != '0);
    assign timeout = (state == ST_RUN) && (run_cnt == CW'(TIMEOUT_CYC - 1));

`ifdef DOTPROD_MEM_OOB_EN
    logic oob_now;

    assign oob_now = (state == ST_RUN) &&
                     ((a_rd_en && !in_range(a_addr, 32'(len))) ||
                      (b_rd_en && !in_range(b_addr, 32'(len))));
    assign err_extra = oob_sticky || oob_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_sticky <= 1'b0;
        end else if (start) begin
            oob_sticky <= 1'b0;
        end else if (oob_now) begin
            oob_sticky <= 1'b1;
        end
    end
`else
    assign err_extra = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len        <= '0;
            wptr       <= '0;
            run_cnt    <= '0;
            kern_rst_n <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            unique case (1'b1)
                idle_or_done: begin
                    if (start) begin
                        res_valid <= 1'b0;
                        res_data  <= '0;
                        res_err   <= 1'b0;
                        wptr      <= '0;
                        run_cnt   <= '0;
                        len       <= len_bad ? '0 : cfg_len;
                        if (len_bad) begin
                            state     <= ST_DONE;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                        end else if (cfg_len == '0) begin
                            state      <= ST_RUN;
                            kern_rst_n <= 1'b1;
                        end else begin
                            state <= ST_LOAD_A;
                        end
                    end
                end
                (state == ST_LOAD_A): begin
                    if (beat) begin
                        wptr <= last_beat ? '0 : wptr + (AW + 1)'(1);
                        if (last_beat) begin
                            state <= ST_LOAD_B;
                        end
                    end
                end
                (state == ST_LOAD_B): begin
                    if (beat) begin
                        wptr <= last_beat ? '0 : wptr + (AW + 1)'(1);
                        if (last_beat) begin
                            state      <= ST_RUN;
                            kern_rst_n <= 1'b1;
                            run_cnt    <= '0;
                        end
                    end
                end
                (state == ST_RUN): begin
                    run_cnt <= run_cnt + CW'(1);
                    if (done_q) begin
                        res_data   <= kern_result;
                        res_valid  <= 1'b1;
                        res_err    <= err_extra;
                        state      <= ST_DONE;
                        kern_rst_n <= 1'b0;
                    end else if (timeout) begin
                        res_valid  <= 1'b1;
                        res_err    <= 1'b1;
                        state      <= ST_DONE;
                        kern_rst_n <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    kern_rst_n <= 1'b0;
                end
            endcase
        end
    end

    dotprod_bank #(
        .DW       (DW),
        .AW       (AW),
        .READ_LAT (READ_LAT)
    ) u_bank_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat && (state == ST_LOAD_A)),
        .waddr (wptr[AW-1:0]),
        .wdata (ld_data),
        .rd_en (a_rd_en),
        .raddr (a_addr),
        .n     (len),
        .rdata (a_in)
    );

    dotprod_bank #(
        .DW       (DW),
        .AW       (AW),
        .READ_LAT (READ_LAT)
    ) u_bank_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat && (state == ST_LOAD_B)),
        .waddr (wptr[AW-1:0]),
        .wdata (ld_data),
        .rd_en (b_rd_en),
        .raddr (b_addr),
        .n     (len),
        .rdata (b_in)
    );

endmodule

// File: tb/tb_dotprod_mem_host.sv
// Bench for dotprod_mem_host with a behavioural kernel and dot-product reference.
// Build with DOTPROD_MEM_OOB_EN to also cover the out-of-range sticky flag.
module tb_dotprod_mem_host;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [AW:0]   cfg_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          kern_rst_n;
    logic [AW:0]   kern_n;
    logic [31:0]   a_addr;
    logic          a_rd_en;
    logic [DW-1:0] a_in;
    logic [31:0]   b_addr;
    logic          b_rd_en;
    logic [DW-1:0] b_in;
    logic [DW-1:0] kern_result;
    logic          kern_done;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_err;
    logic          busy;
`ifdef DOTPROD_MEM_OOB_EN
    logic          oob_sticky;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dotprod_mem_host #(
        .DW          (DW),
        .AW          (AW),
        .READ_LAT    (0),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_len     (cfg_len),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .kern_rst_n  (kern_rst_n),
        .kern_n      (kern_n),
        .a_addr      (a_addr),
        .a_rd_en     (a_rd_en),
        .a_in        (a_in),
        .b_addr      (b_addr),
        .b_rd_en     (b_rd_en),
        .b_in        (b_in),
        .kern_result (kern_result),
        .kern_done   (kern_done),
`ifdef DOTPROD_MEM_OOB_EN
        .oob_sticky  (oob_sticky),
`endif
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_err     (res_err),
        .busy        (busy)
    );

    // Kernel model: walks 0..n-1 reading both ports, then raises done.
    // done stays stale while held in reset and clears on the first free edge.
    logic          k_run  = 1'b0;
    int            k_idx  = 0;
    logic [DW-1:0] k_acc  = '0;
    logic          k_done = 1'b0;
    logic          k_hang = 1'b0;
    logic          k_oob  = 1'b0;

    always @(posedge clk) begin
        if (!kern_rst_n) begin
            k_run <= 1'b0;
        end else if (!k_run) begin
            k_run  <= 1'b1;
            k_idx  <= 0;
            k_acc  <= '0;
            k_done <= 1'b0;
        end else if (!k_done) begin
            if (k_idx < int'(kern_n)) begin
                k_acc <= k_acc + a_in * b_in;
                k_idx <= k_idx + 1;
            end else if (!k_hang) begin
                k_done <= 1'b1;
            end
        end
    end

    always_comb begin
        a_rd_en     = k_run && !k_done && (k_idx < int'(kern_n));
        b_rd_en     = a_rd_en;
        a_addr      = (k_oob && k_idx == 0) ? 32'(kern_n) : 32'(k_idx);
        b_addr      = 32'(k_idx);
        kern_result = k_acc;
        kern_done   = k_done;
    end

    logic [DW-1:0] va [DEPTH];
    logic [DW-1:0] vb [DEPTH];
    logic [DW-1:0] oob_a_obs;
    int            run_cyc;
    logic          krst_seen;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] dot(input int n, input int skip0);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < n; i++) begin
            if (!(skip0 != 0 && i == 0)) s = s + va[i] * vb[i];
        end
        return s;
    endfunction

    task automatic start_job(input int n);
        cfg_start = 1'b1;
        cfg_len   = (AW + 1)'(n);
        cyc();
        cfg_start = 1'b0;
    endtask

    // Sends up to nbeats of A then B; optional bubbles and a stray cfg_start.
    task automatic load(input int n, input bit toggle, input int nbeats,
                        input bit poke);
        for (int i = 0; i < nbeats; i++) begin
            if (toggle && i > 0) begin
                ld_valid = 1'b0;
                cyc();
            end
            if (poke && i == 1) begin
                ld_valid  = 1'b0;
                cfg_start = 1'b1;
                cfg_len   = 7'd5;
                cyc();
                cfg_start = 1'b0;
                chk("poke_ld_ready", 32'(ld_ready), 32'd1);
            end
            if (i == 2 * n - 1) chk("ready_before_last", 32'(ld_ready), 32'd1);
            ld_valid = 1'b1;
            ld_data  = (i < n) ? va[i] : vb[i - n];
            cyc();
        end
        ld_valid = 1'b0;
        if (nbeats == 2 * n) chk("ready_after_last", 32'(ld_ready), 32'd0);
    endtask

    task automatic wait_result();
        run_cyc = 0;
        for (int c = 0; c < 200; c++) begin
            if (res_valid) break;
            if (kern_rst_n) run_cyc++;
            if (k_oob && a_rd_en && a_addr == 32'(kern_n)) oob_a_obs = a_in;
            cyc();
        end
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("kern_frozen", 32'(kern_rst_n), 32'd0);
    endtask

    task automatic run_job(input int n, input bit toggle, input bit poke);
        start_job(n);
        if (n > 0) load(n, toggle, 2 * n, poke);
        wait_result();
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_len   = '0;
        ld_valid  = 1'b0;
        ld_data   = '0;
        oob_a_obs = 32'hdead;
        repeat (3) cyc();

        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_kern_rst_n", 32'(kern_rst_n), 32'd0);
        chk("rst_kern_n", 32'(kern_n), 32'd0);
        chk("rst_a_in", a_in, 32'd0);
        chk("rst_b_in", b_in, 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cyc();

        va[0] = 1; va[1] = 2; va[2] = 3;
        vb[0] = 4; vb[1] = 5; vb[2] = 6;
        run_job(3, 1'b0, 1'b0);
        chk("basic_data", res_data, dot(3, 0));
        chk("basic_err", 32'(res_err), 32'd0);
        chk("basic_busy", 32'(busy), 32'd0);

        run_job(3, 1'b1, 1'b0);
        chk("toggle_data", res_data, 32'd32);
        chk("toggle_err", 32'(res_err), 32'd0);

        // stray load beats while DONE must not disturb the next job
        ld_valid = 1'b1;
        ld_data  = 32'hbad0bad0;
        repeat (3) cyc();
        ld_valid = 1'b0;

        run_job(3, 1'b0, 1'b1);
        chk("poke_data", res_data, 32'd32);
        chk("poke_kern_n", 32'(kern_n), 32'd3);

        run_job(0, 1'b0, 1'b0);
        chk("zero_data", res_data, 32'd0);
        chk("zero_err", 32'(res_err), 32'd0);

        start_job(DEPTH + 1);
        chk("big_busy", 32'(busy), 32'd0);
        chk("big_err", 32'(res_err), 32'd1);
        chk("big_data", res_data, 32'd0);
        krst_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (kern_rst_n) krst_seen = 1'b1;
            cyc();
        end
        chk("big_no_kern", 32'(krst_seen), 32'd0);

        k_hang = 1'b1;
        va[0] = 9; va[1] = 8; vb[0] = 7; vb[1] = 6;
        run_job(2, 1'b0, 1'b0);
        k_hang = 1'b0;
        chk("timeout_cycles", 32'(run_cyc), 32'd16);
        chk("timeout_err", 32'(res_err), 32'd1);

        va[0] = 11; va[1] = 12; va[2] = 13;
        vb[0] = 14; vb[1] = 15; vb[2] = 16;
        start_job(3);
        load(3, 1'b0, 4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ld_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_kern", 32'(kern_rst_n), 32'd0);
        #2 rst_n = 1'b1;
        cyc();
        va[0] = 7; va[1] = 0; vb[0] = 3; vb[1] = 9;
        run_job(2, 1'b0, 1'b0);
        chk("after_rst_data", res_data, 32'd21);

        for (int j = 0; j < 6; j++) begin
            int n;
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) begin
                va[i] = $urandom;
                vb[i] = $urandom;
            end
            run_job(n, j[0], 1'b0);
            chk("rand_data", res_data, dot(n, 0));
            chk("rand_err", 32'(res_err), 32'd0);
        end

`ifdef DOTPROD_MEM_OOB_EN
        chk("oob_clean", 32'(oob_sticky), 32'd0);
        va[0] = 2; va[1] = 3; va[2] = 4;
        vb[0] = 5; vb[1] = 6; vb[2] = 7;
        k_oob = 1'b1;
        run_job(3, 1'b0, 1'b0);
        k_oob = 1'b0;
        chk("oob_a_in", oob_a_obs, 32'd0);
        chk("oob_sticky", 32'(oob_sticky), 32'd1);
        chk("oob_err", 32'(res_err), 32'd1);
        chk("oob_data", res_data, dot(3, 1));
        start_job(3);
        chk("oob_cleared", 32'(oob_sticky), 32'd0);
        load(3, 1'b0, 6, 1'b0);
        wait_result();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
